// File: rtl/ttrng_pool.sv
// Entropy pool: 2-flop synchronised raw channels are XOR-mixed, optionally von Neumann
// debiased (macro TTRNG_VN_DEBIAS_EN), assembled into words and handed out via valid/ready.
module ttrng_pool #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned REP_LIMIT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enabled,
    input  logic [NUM_CH-1:0] raw_bits,
    output logic [WORD_W-1:0] number,
    output logic              valid,
    input  logic              ready,
    output logic              health_fail
);

    localparam int unsigned      CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);

    // Synchroniser and mixer

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic              mixed;

    always_comb begin
        sync1_d = raw_bits;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign mixed = ^sync2_q;

    // Bit source: debiased pairs or the raw mixed bit

    logic emit;
    logic emit_bit;

`ifdef TTRNG_VN_DEBIAS_EN
    typedef enum logic {StFirst, StSecond} vn_state_e;

    vn_state_e state_q, state_d;
    logic      first_q, first_d;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        emit     = 1'b0;
        emit_bit = first_q;
        if (enabled) begin
            unique case (state_q)
                StFirst: begin
                    first_d = mixed;
                    state_d = StSecond;
                end
                StSecond: begin
                    // 01 -> 0, 10 -> 1: the emitted bit is the first of an unequal pair
                    emit    = first_q ^ mixed;
                    state_d = StFirst;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFirst;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end
`else
    assign emit     = enabled;
    assign emit_bit = mixed;
`endif

    // Repetition-count health test

    logic [7:0] rep_q, rep_d;
    logic       last_q, last_d;
    logic       fail_q, fail_d;

    always_comb begin
        rep_d  = rep_q;
        last_d = last_q;
        if (enabled) begin
            if ((rep_q == 8'd0) || (mixed != last_q)) begin
                rep_d  = 8'd1;
                last_d = mixed;
            end else if (rep_q < REP_MAX) begin
                rep_d = rep_q + 8'd1;
            end
        end
        fail_d = fail_q | (rep_q == REP_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q  <= 8'd0;
            last_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            last_q <= last_d;
            fail_q <= fail_d;
        end
    end

    // Accumulator and output slot

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] number_q, number_d;
    logic              valid_q, valid_d;
    logic              full;
    logic              transfer;

    assign full     = (cnt_q == CNT_FULL);
    assign transfer = full && (!valid_q || ready) && !fail_q;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        number_d = number_q;
        valid_d  = valid_q;
        if (fail_q) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready) begin
                valid_d = 1'b0;
            end
            if (transfer) begin
                number_d = acc_q;
                valid_d  = 1'b1;
                // A bit emitted in the transfer cycle starts the next word
                acc_d    = {{(WORD_W-1){1'b0}}, emit & emit_bit};
                cnt_d    = emit ? CNT_W'(1) : '0;
            end else if (emit && !full) begin
                acc_d = {acc_q[WORD_W-2:0], emit_bit};
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            number_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            number_q <= number_d;
            valid_q  <= valid_d;
        end
    end

    assign number      = number_q;
    assign valid       = valid_q & ~fail_q;
    assign health_fail = fail_q;

endmodule

// File: tb/tb_ttrng_pool.sv
// Directed bench for ttrng_pool (NUM_CH=2, WORD_W=8, REP_LIMIT=32); covers both builds
// of TTRNG_VN_DEBIAS_EN.
module tb_ttrng_pool;

    logic       clk;
    logic       reset;
    logic       enabled;
    logic [1:0] raw_bits;
    logic [7:0] number;
    logic       valid;
    logic       ready;
    logic       health_fail;

    int n_checks;
    int n_errors;

    ttrng_pool #(
        .NUM_CH   (2),
        .WORD_W   (8),
        .REP_LIMIT(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enabled    (enabled),
        .raw_bits   (raw_bits),
        .number     (number),
        .valid      (valid),
        .ready      (ready),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raw stream for the backpressure test; words are 00,b1..b6 = 0x34 then b7..b14 = 0xA7
    int pat_bp [1:25] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1,
                          0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};

    initial begin
        logic [3:0] seq;
        int         valid_seen;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        enabled  = 1'b0;
        ready    = 1'b0;
        raw_bits = 2'b00;

        do_reset();
        check_eq("rst_number", 32'(number), 32'h0);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_health", 32'(health_fail), 32'h0);

`ifdef TTRNG_VN_DEBIAS_EN
        // Stream 0,1,1,0: pairs 01,10 -> bits 0,1,... -> 0x55
        seq   = 4'b0110;
        ready = 1'b1;
        enabled = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            raw_bits = {1'b0, seq[(i - 1) % 4]};
            tick();
            if (i == 18) check_eq("vn_pre_valid", 32'(valid), 32'h0);
            if (i == 19) begin
                check_eq("vn_w1_valid", 32'(valid), 32'h1);
                check_eq("vn_w1_number", 32'(number), 32'h55);
            end
            if (i == 20) check_eq("vn_w1_drop", 32'(valid), 32'h0);
            if (i == 35) begin
                check_eq("vn_w2_valid", 32'(valid), 32'h1);
                check_eq("vn_w2_number", 32'(number), 32'h55);
            end
        end

        // Stream 0,0,1,1: only equal pairs, nothing emitted, no health failure
        do_reset();
        seq        = 4'b1100;
        valid_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            raw_bits = {1'b0, seq[(i - 1) % 4]};
            tick();
            if (valid) valid_seen++;
        end
        check_eq("vn_eq_no_word", 32'(valid_seen), 32'h0);
        check_eq("vn_eq_health", 32'(health_fail), 32'h0);
`else
        // Channels 1,0 constant, enabled toggling: one 0xFF word per 16 cycles
        raw_bits = 2'b01;
        ready    = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 1; i <= 34; i++) begin
            enabled = (i % 2 == 1);
            tick();
            if (i == 15) check_eq("tog_pre_valid", 32'(valid), 32'h0);
            if (i == 16) begin
                check_eq("tog_w1_valid", 32'(valid), 32'h1);
                check_eq("tog_w1_number", 32'(number), 32'hFF);
            end
            if (i == 17) check_eq("tog_w1_drop", 32'(valid), 32'h0);
            if (i == 31) check_eq("tog_gap_valid", 32'(valid), 32'h0);
            if (i == 32) begin
                check_eq("tog_w2_valid", 32'(valid), 32'h1);
                check_eq("tog_w2_number", 32'(number), 32'hFF);
            end
        end

        // Backpressure: first word held, second waits, one-cycle ready swaps them
        enabled = 1'b0;
        do_reset();
        enabled = 1'b1;
        ready   = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            raw_bits = 2'(pat_bp[i]);
            ready    = (i == 21);
            tick();
            if (i == 8) begin
                check_eq("bp_pre_valid", 32'(valid), 32'h0);
                check_eq("bp_cnt_full1", 32'(dut.cnt_q), 32'd8);
            end
            if (i == 9) begin
                check_eq("bp_w1_valid", 32'(valid), 32'h1);
                check_eq("bp_w1_number", 32'(number), 32'h34);
            end
            if (i == 20) begin
                check_eq("bp_hold_valid", 32'(valid), 32'h1);
                check_eq("bp_hold_number", 32'(number), 32'h34);
                check_eq("bp_cnt_full2", 32'(dut.cnt_q), 32'd8);
            end
            if (i == 21) begin
                check_eq("bp_w2_valid", 32'(valid), 32'h1);
                check_eq("bp_w2_number", 32'(number), 32'hA7);
            end
            if (i == 22) check_eq("bp_w2_hold", 32'(number), 32'hA7);
            if (i == 25) check_eq("mid_cnt5", 32'(dut.cnt_q), 32'd5);
        end

        // Reset mid-word: everything clears, next word uses only fresh bits
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_number", 32'(number), 32'h0);
        check_eq("mid_valid", 32'(valid), 32'h0);
        check_eq("mid_cnt0", 32'(dut.cnt_q), 32'd0);
        ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            raw_bits = 2'(pat_bp[i]);
            tick();
        end
        check_eq("fresh_valid", 32'(valid), 32'h1);
        check_eq("fresh_number", 32'(number), 32'h34);
`endif

        // Constant zero entropy trips the repetition test after 32 enabled cycles
        enabled = 1'b0;
        do_reset();
        raw_bits = 2'b00;
        ready    = 1'b1;
        enabled  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 32) check_eq("hf_before", 32'(health_fail), 32'h0);
            if (i == 33) begin
                check_eq("hf_set", 32'(health_fail), 32'h1);
                check_eq("hf_valid33", 32'(valid), 32'h0);
            end
        end
        check_eq("hf_valid40", 32'(valid), 32'h0);
        enabled  = 1'b0;
        raw_bits = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        check_eq("hf_sticky", 32'(health_fail), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("hf_cleared", 32'(health_fail), 32'h0);
        check_eq("hf_clr_valid", 32'(valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ttrng_pool.md
TTRNG_POOL -- requirements
Module: ttrng_pool

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, giving the number of raw entropy channels (1..32).
REQ-002 The block SHALL have parameter WORD_W, default 8, giving the output word width (2..32).
REQ-003 The block SHALL have parameter REP_LIMIT, default 32, giving the repetition-count health threshold (2..255).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 enabled  in  1  high = sample, condition and assemble; low = pause, all state held.
REQ-007 raw_bits  in  NUM_CH  asynchronous raw entropy bits, one per channel.
REQ-008 number  out  WORD_W  conditioned random word, registered.
REQ-009 valid  out  1  number holds an unconsumed word.
REQ-010 ready  in  1  consumer accepts number when valid and ready are both high in the same cycle.
REQ-011 health_fail  out  1  sticky repetition-count failure flag.

Function
REQ-012 Each raw_bits channel SHALL pass through a 2-flop synchroniser that is clocked every cycle, independent of enabled.
REQ-013 The mixed bit SHALL be the XOR of all NUM_CH synchronised channels; a raw_bits value applied at edge n SHALL reach the mixed bit at edge n+2.
REQ-014 The debiaser SHALL be a 2-state FSM, FIRST and SECOND, that advances only on cycles where enabled=1: FIRST latches the mixed bit and moves to SECOND; SECOND compares.
REQ-015 In SECOND, pair 01 SHALL emit 0, pair 10 SHALL emit 1, and pairs 00 and 11 SHALL emit nothing; the FSM SHALL then return to FIRST.
REQ-016 Emitted bits SHALL shift into the accumulator at the LSB, so the first emitted bit ends up in the MSB; a bit counter SHALL run 0..WORD_W.
REQ-017 When the counter reaches WORD_W and the output slot is empty, or is being consumed in the same cycle, the accumulator SHALL transfer to number; valid SHALL rise on the next edge and the counter SHALL clear to 0.
REQ-018 If the accumulator is full and the output slot is occupied with ready=0, the accumulator SHALL hold and further emitted bits SHALL be discarded until the transfer occurs.
REQ-019 number SHALL be stable while valid=1 and ready=0; valid SHALL fall after acceptance unless a transfer occurs in the same cycle, in which case valid stays high and number updates.
REQ-020 The repetition counter SHALL count consecutive enabled cycles with an identical mixed bit; it SHALL reload to 1 on change and saturate at REP_LIMIT.
REQ-021 On reaching REP_LIMIT, health_fail SHALL set on the next edge and stay set until reset.
REQ-022 While health_fail=1, valid SHALL be forced to 0, no transfers SHALL occur, and the accumulator and counter SHALL clear.
REQ-023 enabled=0 SHALL freeze the debiaser FSM, accumulator, bit counter and repetition counter; the output handshake SHALL still operate.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL set number=0, valid=0 and health_fail=0.
REQ-025 On reset=1 at a clock edge, the block SHALL clear the accumulator and bit counter, set the FSM to FIRST, clear the repetition counter and clear the synchronisers.
REQ-026 Reset SHALL override every other input in the same cycle, including mid-word assembly and a pending handshake.

Configuration
REQ-027 When the macro TTRNG_VN_DEBIAS_EN is defined, the block SHALL implement the debiaser FSM of REQ-014/015.
REQ-028 When TTRNG_VN_DEBIAS_EN is undefined, the FSM SHALL be absent and the mixed bit SHALL be emitted directly on every enabled cycle, giving WORD_W enabled cycles per word.
REQ-029 The health test, handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 Debias on, NUM_CH=1, WORD_W=8, ready=1, raw stream 0,1,1,0 repeated -> number=0x55 with valid high for one cycle, then repeats.
REQ-031 Debias on, stream 0,0,1,1 repeated -> no word is ever emitted, and health_fail stays 0 with REP_LIMIT=32.
REQ-032 ready=0 with continuous entropy -> first word held stable; the second word waits in the accumulator; when ready=1 for one cycle, the second word appears on the next edge and valid stays 1.
REQ-033 Constant raw_bits=0 with enabled=1 for 40 cycles, REP_LIMIT=32 -> health_fail=1 and valid=0; it stays so until reset, which clears it.
REQ-034 Reset asserted mid-word (counter=5) -> next cycle number=0, valid=0 and counter=0; the next word is assembled from fresh bits only.
REQ-035 Debias off, NUM_CH=2, channels 1,0 constant with enabled toggling every cycle -> one word of 0xFF per 16 cycles.
